// File: rtl/rca13_result_checker.sv
// rca13_result_checker: registers operands onto a ripple-carry adder, samples its result after a settle
// interval, compares it against a behavioural sum and keeps saturating pass/fail counters.
module rca13_result_checker #(
    parameter int WIDTH         = 13,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_add_term1,
    output logic [WIDTH-1:0] o_add_term2,
    input  logic [WIDTH:0]   i_add_result,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH:0]   o_res_sum,
    output logic             o_res_mismatch,
    input  logic             i_clear_counts,
    output logic [CNT_W-1:0] o_pass_count,
    output logic [CNT_W-1:0] o_fail_count
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, HOLD} state_t;
    state_t state, state_nxt;
    logic [3:0]     settle_cnt;
    logic [WIDTH:0] expected;
    logic           accept, mismatch_now;
    assign accept       = (state == IDLE) && i_op_valid;
    assign mismatch_now = (i_add_result != expected);
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        o_op_ready  = (state == IDLE);
        o_res_valid = (state == HOLD);
        state_nxt   = (state == IDLE)   ? (i_op_valid ? SETTLE : IDLE) :
                      (state == SETTLE) ? (settle_cnt == 4'd0 ? CHECK : SETTLE) :
                      (state == CHECK)  ? HOLD :
                      (i_res_ready ? IDLE : HOLD);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_add_term1    <= '0;
            o_add_term2    <= '0;
            expected       <= '0;
            settle_cnt     <= '0;
            o_res_sum      <= '0;
            o_res_mismatch <= 1'b0;
        end else begin
            if (accept) begin
                o_add_term1 <= i_op_a;
                o_add_term2 <= i_op_b;
                expected    <= {1'b0, i_op_a} + {1'b0, i_op_b};
                settle_cnt  <= 4'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (state == CHECK) begin
                o_res_sum      <= i_add_result;
                o_res_mismatch <= mismatch_now;
            end
        end
    end
    // A clear coinciding with a CHECK increment wins; the increment is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear_counts) begin
            o_pass_count <= '0;
            o_fail_count <= '0;
        end else if (state == CHECK) begin
            if (mismatch_now) begin
                if (~&o_fail_count) o_fail_count <= o_fail_count + CNT_W'(1);
            end else begin
                if (~&o_pass_count) o_pass_count <= o_pass_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rca13_result_checker.sv
// tb_rca13_result_checker: directed scoreboard bench; two instances (16-bit and 4-bit counters) share stimulus.
module tb_rca13_result_checker;
    localparam int W = 13;
    logic         clk = 0, rst = 1, op_valid = 0, res_ready = 1, clear = 0;
    logic [W-1:0] a = '0, b = '0;
    logic         op_ready, res_valid, mm, op_ready2, res_valid2, mm2;
    logic [W-1:0] t1, t2, t1b, t2b;
    logic [W:0]   r1, r2, sum, sum2;
    logic [15:0]  pc, fc;
    logic [3:0]   pc2, fc2;
    typedef struct {logic [W:0] sum; logic mm; bit counted;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int p16 = 0, f16 = 0, p4 = 0, f4 = 0;
    int checks = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder stand-in with one planted fault: 5+5 returns 0.
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x == 5 && y == 5) ? '0 : {1'b0, x} + {1'b0, y};
    endfunction
    assign r1 = model_add(t1, t2);
    assign r2 = model_add(t1b, t2b);

    rca13_result_checker #(.WIDTH(W), .SETTLE_CYCLES(2), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid), .o_op_ready(op_ready),
        .i_op_a(a), .i_op_b(b), .o_add_term1(t1), .o_add_term2(t2), .i_add_result(r1),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_sum(sum), .o_res_mismatch(mm),
        .i_clear_counts(clear), .o_pass_count(pc), .o_fail_count(fc));
    rca13_result_checker #(.WIDTH(W), .SETTLE_CYCLES(2), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid), .o_op_ready(op_ready2),
        .i_op_a(a), .i_op_b(b), .o_add_term1(t1b), .o_add_term2(t2b), .i_add_result(r2),
        .o_res_valid(res_valid2), .i_res_ready(res_ready), .o_res_sum(sum2), .o_res_mismatch(mm2),
        .i_clear_counts(clear), .o_pass_count(pc2), .o_fail_count(fc2));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    function automatic void push(input logic [W-1:0] x, input logic [W-1:0] y, input bit counted);
        exp_t e;
        e.mm      = (x == 5 && y == 5);
        e.sum     = e.mm ? '0 : {1'b0, x} + {1'b0, y};
        e.counted = counted;
        sb.push_back(e);
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit counted);
        int n = 0;
        a = x; b = y; op_valid = 1;
        @(negedge clk);
        while (!op_ready && n < 50) begin n++; @(negedge clk); end
        chk("accept_wait", op_ready, 1);
        push(x, y, counted);
        @(posedge clk) #1 op_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin n++; @(negedge clk); end
        chk("drain", sb.size(), 0);
        @(posedge clk) #1;
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("res_sum", sum, mon_e.sum);
                chk("res_mismatch", mm, mon_e.mm);
                chk("res_sum_c4", sum2, mon_e.sum);
                chk("res_mismatch_c4", mm2, mon_e.mm);
                if (mon_e.counted) begin
                    if (mon_e.mm) begin
                        f16 = f16 < 65535 ? f16 + 1 : f16;
                        f4  = f4 < 15 ? f4 + 1 : f4;
                    end else begin
                        p16 = p16 < 65535 ? p16 + 1 : p16;
                        p4  = p4 < 15 ? p4 + 1 : p4;
                    end
                end
                chk("pass_count", pc, p16);
                chk("fail_count", fc, f16);
                chk("pass_count_c4", pc2, p4);
                chk("fail_count_c4", fc2, f4);
            end
        end
    end

    initial begin
        logic [W:0] s0;
        logic       m0;
        int         first_cyc, last_cyc, n;
        logic [W-1:0] x, y;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_ready", op_ready, 1);
        chk("rst_op_ready_c4", op_ready2, 1);
        chk("rst_res_valid", res_valid2 | res_valid, 0);
        chk("rst_terms", {t1, t2}, 0);
        chk("rst_sum", sum, 0);
        chk("rst_counts", {pc, fc}, 0);
        rst = 0;

        // carry chain through all 13 bits, plus result latency
        send(13'h1FFF, 13'h0001, 1);
        for (int i = 0; i < 3; i++) begin @(negedge clk); chk("valid_early", res_valid, 0); end
        @(negedge clk); chk("valid_rise", res_valid, 1);
        chk("carry_sum", sum, 32'h2000);
        drain();
        chk("carry_pass", pc, 1);

        send(13'd5, 13'd5, 1);
        drain();
        chk("fault_fail", fc, 1);
        chk("fault_pass", pc, 1);

        // backpressure with a pending operand pair
        res_ready = 0;
        send(13'd1, 13'd2, 1);
        n = 0;
        while (!res_valid && n < 20) begin n++; @(negedge clk); end
        chk("bp_valid", res_valid, 1);
        s0 = sum; m0 = mm;
        a = 13'd3; b = 13'd4; op_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_sum", sum, s0);
            chk("bp_hold_mm", mm, m0);
            chk("bp_op_ready", op_ready, 0);
            chk("bp_not_consumed", t1, 1);
        end
        chk("bp_sum", s0, 3);
        @(posedge clk) #1 res_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_hs", op_ready, 1);
        push(13'd3, 13'd4, 1);
        @(posedge clk) #1 op_valid = 0;
        chk("pending_accepted", t1, 3);
        drain();

        // reset while settling
        send(13'h0AAA, 13'h1555, 1);
        rst = 1;
        @(posedge clk) #1 rst = 0;
        sb.delete();
        p16 = 0; f16 = 0; p4 = 0; f4 = 0;
        chk("midrst_terms", {t1, t2}, 0);
        chk("midrst_counts", {pc, fc}, 0);
        chk("midrst_counts_c4", {pc2, fc2}, 0);
        chk("midrst_valid", res_valid, 0);
        chk("midrst_ready", op_ready, 1);
        chk("midrst_sum", sum, 0);
        repeat (6) @(posedge clk);
        #1 chk("midrst_no_result", res_valid, 0);

        // saturation of the 4-bit counter
        for (int i = 0; i < 17; i++) send(W'(i * 7), W'(i + 100), 1);
        drain();
        chk("sat_pass_c4", pc2, 15);
        chk("sat_pass", pc, 17);

        // clear during CHECK of a mismatch
        send(13'd5, 13'd5, 0);
        @(posedge clk);
        @(posedge clk) #1 clear = 1;
        p16 = 0; f16 = 0; p4 = 0; f4 = 0;
        @(posedge clk) #1 clear = 0;
        drain();
        chk("clear_counts", {pc, fc}, 0);
        chk("clear_counts_c4", {pc2, fc2}, 0);

        // throughput with valid and ready held high
        res_ready = 1; op_valid = 1;
        first_cyc = 0; last_cyc = 0;
        for (int k = 0; k < 100; k++) begin
            do begin
                x = W'($urandom_range(0, 8191));
                y = W'($urandom_range(0, 8191));
            end while (x == 5 && y == 5);
            a = x; b = y;
            n = 0;
            @(negedge clk);
            while (!op_ready && n < 20) begin n++; @(negedge clk); end
            if (!op_ready) chk("tp_accept", op_ready, 1);
            push(x, y, 1);
            if (k == 0) first_cyc = cyc;
            last_cyc = cyc;
            @(posedge clk) #1;
        end
        op_valid = 0;
        chk("tp_period", last_cyc - first_cyc, 99 * 5);
        drain();
        chk("tp_pass", pc, 100);
        chk("tp_fail", fc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
